mem_arbiter: RTL and testbench

Single-port memory arbiter that shares one memory bus between instruction fetch and the data side of the execute stage. Data accesses from execute have priority, with a bounded-run guard so fetch cannot starve. Generates the `d_stall` term that feeds the pipeline's `stall_in` while a data access is pending. Sits between the pipeline stages and the memory/bus slave.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle shared by the fetch/data requesters, the memory arbiter and the bus slave.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_ready;
   logic [DATA_W-1:0] f_rdata;

   logic              d_req;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;
   logic              d_stall;

   logic              m_req;
   logic              m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ready;
   logic [DATA_W-1:0] m_rdata;

   modport master (
      input  f_req, f_addr, d_req, d_write, d_addr, d_wdata, m_ready, m_rdata,
      output f_ready, f_rdata, d_ready, d_rdata, d_stall, m_req, m_write, m_addr, m_wdata
   );

   modport slave (
      output f_req, f_addr, d_req, d_write, d_addr, d_wdata, m_ready, m_rdata,
      input  f_ready, f_rdata, d_ready, d_rdata, d_stall, m_req, m_write, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data side has priority over fetch, but after MAX_DATA_RUN
// consecutive data grants with fetch waiting, fetch gets the next slot. MAX_DATA_RUN >= 1.
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);
   localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_F = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;

   logic [1:0]        state;
   logic [RUN_W-1:0]  run_cnt;
   logic              m_req_q;
   logic              m_write_q;
   logic [ADDR_W-1:0] m_addr_q;
   logic [DATA_W-1:0] m_wdata_q;
   logic              grant_d;

   // Data wins unless fetch is waiting and data has already used its whole run.
   assign grant_d = bus.d_req & (~bus.f_req | (run_cnt < RUN_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         run_cnt   <= '0;
         m_req_q   <= 1'b0;
         m_write_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state     <= BUSY_D;
                  m_req_q   <= 1'b1;
                  m_write_q <= bus.d_write;
                  m_addr_q  <= bus.d_addr;
                  m_wdata_q <= bus.d_wdata;
                  if (!bus.f_req)
                     run_cnt <= '0;
                  else if (run_cnt != RUN_MAX)
                     run_cnt <= run_cnt + RUN_W'(1);
               end else if (bus.f_req) begin
                  state     <= BUSY_F;
                  m_req_q   <= 1'b1;
                  m_write_q <= 1'b0;
                  m_addr_q  <= bus.f_addr;
                  run_cnt   <= '0;
               end
            end
            BUSY_F, BUSY_D: begin
               // Bus signals stay frozen until the slave completes.
               if (bus.m_ready) begin
                  state   <= IDLE;
                  m_req_q <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               m_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m_req   = m_req_q;
   assign bus.m_write = m_write_q;
   assign bus.m_addr  = m_addr_q;
   assign bus.m_wdata = m_wdata_q;

   assign bus.f_ready = bus.m_ready & (state == BUSY_F);
   assign bus.d_ready = bus.m_ready & (state == BUSY_D);
   assign bus.f_rdata = bus.m_rdata;
   assign bus.d_rdata = bus.m_rdata;

   // Deliberately independent of rst so the pipeline stalls whenever a data access is outstanding.
   assign bus.d_stall = bus.d_req & ~bus.d_ready;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected bus grants are queued as each scenario is set up
// and compared as the arbiter issues them; a behavioural slave answers with a set latency.
module tb_mem_arbiter;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int MAX_RUN = 4;

   typedef struct packed {
      logic        is_d;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } grant_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_RUN(MAX_RUN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   grant_t      exp_q[$];
   grant_t      cur;
   int          checks = 0;
   int          errors = 0;
   bit          in_txn;
   int          busy, lat;
   bit          spur;
   bit          f_en;
   int          f_left, d_left, f_cnt, d_cnt, pf_cnt, pd_cnt;
   logic        d_wr;
   logic [31:0] f_base, d_base, wd_base, rd_val, last_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic push_d();
      exp_q.push_back('{1'b1, d_wr, d_base + 32'(4 * pd_cnt), wd_base + 32'(pd_cnt)});
      last_wdata = wd_base + 32'(pd_cnt);
      pd_cnt++;
   endtask

   task automatic push_f();
      exp_q.push_back('{1'b0, 1'b0, f_base + 32'(4 * pf_cnt), last_wdata});
      pf_cnt++;
   endtask

   // One clock cycle, entered and left at posedge+1: drive requesters and slave, then check.
   task automatic cycle();
      logic rdy_d, rdy_f;
      bus.f_req   = f_en && (f_left > 0);
      bus.f_addr  = f_base + 32'(4 * f_cnt);
      bus.d_req   = (d_left > 0);
      bus.d_write = d_wr;
      bus.d_addr  = d_base + 32'(4 * d_cnt);
      bus.d_wdata = wd_base + 32'(d_cnt);
      if (bus.m_req) begin
         busy++;
         bus.m_ready = (busy == lat);
      end else begin
         bus.m_ready = spur;
      end
      bus.m_rdata = rd_val;
      #1;
      if (bus.m_req) begin
         if (!in_txn) begin
            chk1("grant_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            in_txn = 1'b1;
         end
         chk1("m_write", bus.m_write, cur.wr);
         chk("m_addr", bus.m_addr, cur.addr);
         chk("m_wdata", bus.m_wdata, cur.wdata);
      end
      rdy_d = bus.m_ready && in_txn && cur.is_d;
      rdy_f = bus.m_ready && in_txn && !cur.is_d;
      chk1("f_ready", bus.f_ready, rdy_f);
      chk1("d_ready", bus.d_ready, rdy_d);
      chk1("d_stall", bus.d_stall, bus.d_req & ~rdy_d);
      if (rdy_f) chk("f_rdata", bus.f_rdata, rd_val);
      if (rdy_d) chk("d_rdata", bus.d_rdata, rd_val);
      if (rdy_f || rdy_d) begin
         in_txn = 1'b0;
         busy   = 0;
         rd_val = rd_val + 32'h0101_0101;
         if (rdy_f) begin f_left--; f_cnt++; end
         else       begin d_left--; d_cnt++; end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_done(input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (exp_q.size() == 0 && !in_txn) begin
            done = 1'b1;
            break;
         end
      end
      chk1("drain_in_budget", done, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_txn = 0; busy = 0; lat = 1; spur = 0; f_en = 1; d_wr = 0;
      f_left = 0; d_left = 0; f_cnt = 0; d_cnt = 0; pf_cnt = 0; pd_cnt = 0;
      f_base = '0; d_base = '0; wd_base = '0; rd_val = '0; last_wdata = '0;
      bus.f_req = 0; bus.f_addr = '0; bus.d_req = 1; bus.d_write = 0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.m_ready = 0; bus.m_rdata = '0;

      // Reset state; d_stall must track d_req even while rst is held.
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_m_req", bus.m_req, 1'b0);
      chk1("rst_m_write", bus.m_write, 1'b0);
      chk("rst_m_addr", bus.m_addr, 32'h0);
      chk("rst_m_wdata", bus.m_wdata, 32'h0);
      chk1("rst_f_ready", bus.f_ready, 1'b0);
      chk1("rst_d_ready", bus.d_ready, 1'b0);
      chk1("rst_d_stall_hi", bus.d_stall, 1'b1);
      bus.d_req = 0;
      #1;
      chk1("rst_d_stall_lo", bus.d_stall, 1'b0);
      rst = 1'b0;

      // Spurious slave ready in IDLE with nobody requesting.
      spur = 1; cycle(); spur = 0;
      repeat (2) cycle();

      // Fetch alone, single-cycle slave.
      f_base = 32'h100; rd_val = 32'hDEAD_BEEF; lat = 1;
      f_cnt = 0; pf_cnt = 0; f_left = 1;
      push_f();
      run_until_done(20);
      repeat (2) cycle();

      // Store with three cycles of bus occupancy.
      d_wr = 1; d_base = 32'h2000; wd_base = 32'h1234_5678; lat = 3;
      d_cnt = 0; pd_cnt = 0; d_left = 1;
      push_d();
      run_until_done(20);
      repeat (2) cycle();

      // Steady contention, zero-wait slave: D,D,D,D,F,D then the last fetch.
      d_wr = 0; d_base = 32'h4000; wd_base = 32'hA0; f_base = 32'h800; lat = 1;
      d_cnt = 0; pd_cnt = 0; f_cnt = 0; pf_cnt = 0; f_left = 2; d_left = 5;
      repeat (4) push_d();
      push_f(); push_d(); push_f();
      run_until_done(60);
      repeat (2) cycle();

      // Run counter clears on a data grant with fetch idle.
      d_base = 32'h5000; wd_base = 32'hB0; f_base = 32'h900;
      d_cnt = 0; pd_cnt = 0; f_cnt = 0; pf_cnt = 0; f_left = 1; d_left = 2;
      repeat (2) push_d();
      run_until_done(20);
      f_en = 0; d_left = 1;
      push_d();
      run_until_done(20);
      f_en = 1; d_left = 5;
      repeat (4) push_d();
      push_f(); push_d();
      run_until_done(60);
      repeat (2) cycle();

      // Reset in the middle of a slow data access abandons it without a ready pulse.
      d_base = 32'h6000; wd_base = 32'hC0; lat = 50;
      d_cnt = 0; pd_cnt = 0; d_left = 1;
      push_d();
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0; d_left = 0; in_txn = 0; busy = 0; lat = 1; last_wdata = '0;
      chk1("midrst_m_req", bus.m_req, 1'b0);
      chk("midrst_q_empty", 32'(exp_q.size()), 32'h0);
      spur = 1; cycle(); spur = 0;
      repeat (2) cycle();

      // Fetch after reset: m_wdata must be back to zero.
      f_base = 32'h140; rd_val = 32'h5A5A_0001;
      f_cnt = 0; pf_cnt = 0; f_left = 1;
      push_f();
      run_until_done(20);
      repeat (2) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
